datapath_mc: RTL

//  Parametrised multi-cycle successor of the lab datapath: NUM_REGS x DATA_W register file,
//  ADD/SUB in one cycle, iterative shift-add MUL over DATA_W cycles, valid/ready instruction

---
 rtl/datapath_mc.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/datapath_mc.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_mc
//  Description : Parametrised multi-cycle datapath. NUM_REGS x DATA_W register
//                file with single-cycle COPY/LOAD/ADD/SUB, iterative shift-add
//                MUL over DATA_W cycles, valid/ready instruction handshake and
//                registered retire (done) / overflow flags. Register 0 drives
//                outreg_data.
//                Optional build macro: DP_STICKY_OVF_EN (sticky overflow,
//                cleared by ovf_clr).
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_mc #(
    parameter int DATA_W   = 17,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [SEL_W-1:0]  src1,
    input  logic [SEL_W-1:0]  src2,
    input  logic [SEL_W-1:0]  dest,
    input  logic [DATA_W-1:0] ext_data1,
    input  logic [DATA_W-1:0] ext_data2,
    input  logic              ovf_clr,
    output logic              done,
    output logic              overflow,
    output logic [DATA_W-1:0] outreg_data
);

    localparam int         c_CNT_W   = $clog2(DATA_W + 1);
    localparam logic [2:0] c_OP_NOP  = 3'b000;
    localparam logic [2:0] c_OP_COPY = 3'b001;
    localparam logic [2:0] c_OP_LD1  = 3'b010;
    localparam logic [2:0] c_OP_LD2  = 3'b011;
    localparam logic [2:0] c_OP_ADD  = 3'b100;
    localparam logic [2:0] c_OP_SUB  = 3'b110;
    localparam logic [2:0] c_OP_MUL  = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [DATA_W-1:0]       r_regs [NUM_REGS];
    logic [2*DATA_W-1:0]     r_acc;
    logic [2*DATA_W-1:0]     r_mcand;
    logic [DATA_W-1:0]       r_mplier;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [SEL_W-1:0]        r_dest;
    logic                    r_done;
    logic                    r_ovf;

    logic [DATA_W-1:0]       w_rd1;
    logic [DATA_W-1:0]       w_rd2;
    logic [DATA_W:0]         w_sum;
    logic                    w_accept;
    logic                    w_we;
    logic [DATA_W-1:0]       w_wdata;
    logic                    w_ovf;
    logic [2*DATA_W-1:0]     w_acc_next;
    logic                    w_mul_last;
    logic                    w_retire;
    logic                    w_ovf_new;

    // Combinational register reads; a same-cycle write to the same index is
    // seen only by the next instruction.
    assign w_rd1       = r_regs[src1];
    assign w_rd2       = r_regs[src2];
    assign w_sum       = {1'b0, w_rd1} + {1'b0, w_rd2};

    assign in_ready    = !rst && (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign outreg_data = r_regs[0];
    assign done        = r_done;
    assign overflow    = r_ovf;

    // Multiplier step: add the shifted multiplicand when the multiplier LSB is set.
    assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last  = (r_state == ST_MUL) && (r_cnt == c_CNT_W'(1));

    // Single-cycle op decode: write enable, write data and overflow result.
    always_comb begin
        w_we    = 1'b0;
        w_wdata = '0;
        w_ovf   = 1'b0;
        case (op)
            c_OP_COPY: begin
                w_we    = 1'b1;
                w_wdata = w_rd1;
            end
            c_OP_LD1: begin
                w_we    = 1'b1;
                w_wdata = ext_data1;
            end
            c_OP_LD2: begin
                w_we    = 1'b1;
                w_wdata = ext_data2;
            end
            c_OP_ADD: begin
                w_we    = 1'b1;
                w_wdata = w_sum[DATA_W-1:0];
                w_ovf   = w_sum[DATA_W];
            end
            c_OP_SUB: begin
                w_we    = 1'b1;
                w_wdata = w_rd1 - w_rd2;
                w_ovf   = (w_rd1 < w_rd2);
            end
            default: begin
                // NOP, reserved 101 and MUL write nothing in this cycle
                w_we    = 1'b0;
            end
        endcase
    end

    // Retire event and the overflow value it carries.
    assign w_retire  = ((r_state == ST_IDLE) && w_accept && (op != c_OP_MUL)) || w_mul_last;
    assign w_ovf_new = (r_state == ST_MUL) ? (|w_acc_next[2*DATA_W-1:DATA_W]) : w_ovf;

    // Control FSM, register file writes and the iterative multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_dest   <= '0;
            r_done   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done <= w_retire;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (op == c_OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= {{DATA_W{1'b0}}, w_rd1};
                            r_mplier <= w_rd2;
                            r_dest   <= dest;
                            r_cnt    <= c_CNT_W'(DATA_W);
                            r_state  <= ST_MUL;
                        end else if (w_we) begin
                            r_regs[dest] <= w_wdata;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - c_CNT_W'(1);
                    if (w_mul_last) begin
                        r_regs[r_dest] <= w_acc_next[DATA_W-1:0];
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DP_STICKY_OVF_EN
    // Sticky overflow: accumulates across retires until ovf_clr, which wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end else if (w_retire) begin
            r_ovf <= r_ovf | w_ovf_new;
        end
    end
`else
    // ovf_clr has no function without the sticky option.
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;

    // Overflow reflects the most recently retired instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_retire) begin
            r_ovf <= w_ovf_new;
        end
    end
`endif

endmodule
`default_nettype wire
